jtninja_frame_trig: RTL and testbench
=====================================

# jtninja_frame_trig

Synthesizable frame-counting and capture-window generator for the simulation harness. It synchronises the game's vertical sync and the ROM-download indicator, counts frames from the end of download, and produces the 32-bit frame count plus waveform-capture enable/start/stop strobes and a finish request. The downstream waveform-dump control stage consumes these outputs. It also exposes the frame count and a lost-VS flag to the test top level.

## Interface
Parameters:
- START_FRAME, 0: frame number at which capture opens; 0 means open immediately on leaving WAIT_DL.
- STOP_FRAME, 0: frame number at which capture closes; 0 means never close.
- MAX_FRAME, 0: frame number that raises finish; 0 means never.
- LOADROM, 1: 1 means wait for a download cycle after reset; 0 means skip WAIT_DL.
- WDOG_CYCLES, 2000000: clk cycles without a frame edge before vs_lost sets.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- vs  in  1  vertical sync, asynchronous to clk, active-low pulse
- dwnld  in  1  download in progress (LED), asynchronous
- frame_cnt  out  32  frames completed since download end
- frame_edge  out  1  one-cycle pulse per counted frame
- dump_en  out  1  capture window open
- dump_start  out  1  one-cycle pulse when dump_en rises
- dump_stop  out  1  one-cycle pulse when dump_en falls
- finish  out  1  sticky finish request
- vs_lost  out  1  watchdog flag

## Operation
- vs and dwnld each pass through a 2-flop synchroniser. Edges are detected on the synchronised copies.
- A frame edge is the falling edge of synchronised vs. It is counted only outside WAIT_DL.
- State machine states: WAIT_DL, ARMED, DUMPING, DONE.
  - Reset state is WAIT_DL if LOADROM=1, otherwise ARMED.
  - WAIT_DL to ARMED: on the synchronised dwnld falling edge. frame_cnt clears to 0 on this transition.
  - ARMED to DUMPING: if START_FRAME=0, on the cycle after entry to ARMED. Otherwise, on the frame edge whose new frame_cnt equals START_FRAME.
  - DUMPING to DONE: on the frame edge whose new frame_cnt equals STOP_FRAME, when STOP_FRAME is nonzero.
  - DONE is terminal until reset or a new download.
  - Any state to WAIT_DL: on a synchronised dwnld rising edge. This takes priority over every other transition in the same cycle.
- dump_en is 1 exactly in DUMPING. dump_start and dump_stop pulse on the cycle dump_en changes. Leaving DUMPING because of dwnld also pulses dump_stop.
- If STOP_FRAME is nonzero and STOP_FRAME is at most START_FRAME, the ARMED-to-DUMPING transition is skipped and the block goes straight to DONE. No pulses are produced.
- finish sets on the frame edge where the new frame_cnt equals MAX_FRAME (MAX_FRAME nonzero). It clears only on reset.
- frame_cnt increments by 1 per frame edge and saturates at 0xFFFFFFFF.
- Watchdog:
  - A counter clears on every frame edge, and on entry to ARMED.
  - It counts otherwise and saturates.
  - vs_lost is 1 while the counter is at or above WDOG_CYCLES. It is held 0 in WAIT_DL.

## Timing
- All outputs are registered.
- Reset values: frame_cnt=0, frame_edge=0, dump_en=0, dump_start=0, dump_stop=0, finish=0, vs_lost=0.
- Latency from vs falling at the input pin to frame_edge=1: 3 clk edges (2 synchroniser stages plus 1 edge register). frame_cnt shows the new value in the same cycle as frame_edge.
- dump_start, dump_stop and finish assert in the same cycle as the frame_edge that causes them.
- Latency from dwnld falling at the pin to entering ARMED: 3 clk edges. frame_cnt=0 is visible in that cycle. With START_FRAME=0, dump_en rises 1 cycle later.
- A vs pulse shorter than 2 clk periods may be missed. This is acceptable.
- A dwnld rising edge and a frame edge in the same cycle: the frame is not counted, and frame_cnt holds its value.
- Asserting rst_n mid-capture drops dump_en immediately (asynchronously) with no dump_stop pulse.

## Test plan
- Reset with LOADROM=1. Pulse dwnld high for 100 cycles, then apply 5 vs pulses. Required: frame_cnt=5, and exactly 5 frame_edge pulses. frame_edge appears 3 cycles after each vs fall.
- START_FRAME=3, STOP_FRAME=6. Apply 10 frames after download. Required: dump_start with frame_cnt=3, dump_stop with frame_cnt=6, dump_en high for exactly 3 frame periods, final state DONE.
- START_FRAME=0, LOADROM=0. Required: dump_en=1 on the 2nd cycle after reset release, with no vs activity.
- MAX_FRAME=4. Required: finish rises with the 4th frame_edge and stays 1 through 4 further frames.
- In DUMPING at frame 7, raise dwnld. Required: dump_stop pulse, dump_en=0 and frame_cnt holds 7. On dwnld fall, frame_cnt=0 and the capture re-arms.
- WDOG_CYCLES=50, no vs after download. Required: vs_lost=1 from cycle 50 after ARMED entry. The next vs fall clears vs_lost 3 cycles later.

Source files
------------

// File: rtl/jtninja_frame_trig.sv
// Frame counter and capture-window generator for the simulation harness.
// Synchronises vs/dwnld, counts frames after download and drives dump strobes.
module jtninja_frame_trig #(
  parameter logic [31:0] START_FRAME = 32'd0,
  parameter logic [31:0] STOP_FRAME  = 32'd0,
  parameter logic [31:0] MAX_FRAME   = 32'd0,
  parameter bit          LOADROM     = 1'b1,
  parameter int unsigned WDOG_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs,
  input  logic        dwnld,
  output logic [31:0] frame_cnt,
  output logic        frame_edge,
  output logic        dump_en,
  output logic        dump_start,
  output logic        dump_stop,
  output logic        finish,
  output logic        vs_lost
);

  localparam logic [1:0] ST_WAIT_DL  = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_DUMPING  = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;
  localparam logic [1:0] ST_RESET    = LOADROM ? ST_WAIT_DL : ST_ARMED;

  // A stop frame at or before the start frame means the window never opens.
  localparam bit SKIP_DUMP = (STOP_FRAME != 32'd0) && (STOP_FRAME <= START_FRAME);

  localparam int WD_W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYCLES);

  // [0],[1] are the synchroniser stages, [2] is the previous synchronised value.
  logic [2:0]      vs_sync_q;
  logic [2:0]      dl_sync_q;
  logic [1:0]      state_q, state_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;
  logic            finish_q, finish_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            frame_edge_q, dump_en_q, dump_start_q, dump_stop_q, vs_lost_q;
  logic            vs_fall, dl_rise, dl_fall, counted;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync_q <= 3'b111;
      dl_sync_q <= 3'b000;
    end else begin
      vs_sync_q <= {vs_sync_q[1:0], vs};
      dl_sync_q <= {dl_sync_q[1:0], dwnld};
    end
  end

  assign vs_fall = vs_sync_q[2] & ~vs_sync_q[1];
  assign dl_rise = ~dl_sync_q[2] & dl_sync_q[1];
  assign dl_fall = dl_sync_q[2] & ~dl_sync_q[1];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    finish_d    = finish_q;
    counted     = 1'b0;

    if (dl_rise) begin
      state_d = ST_WAIT_DL;
    end else begin
      if (state_q != ST_WAIT_DL && vs_fall) begin
        counted = 1'b1;
        if (frame_cnt_q != 32'hFFFF_FFFF) frame_cnt_d = frame_cnt_q + 32'd1;
        if (MAX_FRAME != 32'd0 && frame_cnt_d == MAX_FRAME) finish_d = 1'b1;
      end

      case (state_q)
        ST_WAIT_DL: begin
          if (dl_fall) begin
            state_d     = ST_ARMED;
            frame_cnt_d = 32'd0;
          end
        end
        ST_ARMED: begin
          if (START_FRAME == 32'd0) begin
            state_d = ST_DUMPING;
          end else if (counted && frame_cnt_d == START_FRAME) begin
            state_d = SKIP_DUMP ? ST_DONE : ST_DUMPING;
          end
        end
        ST_DUMPING: begin
          if (STOP_FRAME != 32'd0 && counted && frame_cnt_d == STOP_FRAME) state_d = ST_DONE;
        end
        default: ;
      endcase
    end

    if (counted || (state_q == ST_WAIT_DL && state_d == ST_ARMED)) begin
      wd_d = '0;
    end else if (wd_q != '1) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      frame_cnt_q  <= 32'd0;
      finish_q     <= 1'b0;
      wd_q         <= '0;
      frame_edge_q <= 1'b0;
      dump_en_q    <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
      vs_lost_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      finish_q     <= finish_d;
      wd_q         <= wd_d;
      frame_edge_q <= counted;
      dump_en_q    <= (state_d == ST_DUMPING);
      dump_start_q <= (state_d == ST_DUMPING) && (state_q != ST_DUMPING);
      dump_stop_q  <= (state_q == ST_DUMPING) && (state_d != ST_DUMPING);
      vs_lost_q    <= (state_d != ST_WAIT_DL) && (wd_d >= WD_LIMIT);
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign frame_edge = frame_edge_q;
  assign dump_en    = dump_en_q;
  assign dump_start = dump_start_q;
  assign dump_stop  = dump_stop_q;
  assign finish     = finish_q;
  assign vs_lost    = vs_lost_q;

endmodule

// File: tb/tb_jtninja_frame_trig.sv
// Directed bench for jtninja_frame_trig: four parameterisations share one clock,
// reset and vs; dut_b has its own dwnld to exercise the mid-capture download.
module tb_jtninja_frame_trig;

  logic clk = 1'b0;
  logic rst_n, vs, dwnld_a, dwnld_b;

  logic [31:0] frame_cnt_a, frame_cnt_b, frame_cnt_c, frame_cnt_d;
  logic fe_a, en_a, st_a, sp_a, fin_a, lost_a;
  logic fe_b, en_b, st_b, sp_b, fin_b, lost_b;
  logic fe_c, en_c, st_c, sp_c, fin_c, lost_c;
  logic fe_d, en_d, st_d, sp_d, fin_d, lost_d;

  int errors = 0;
  int checks = 0;

  int fe_cnt_a = 0, start_cnt_a = 0, stop_cnt_a = 0, en_cycles_a = 0;
  int start_at_a = -1, stop_at_a = -1;
  int start_cnt_d = 0, stop_cnt_d = 0, en_cycles_d = 0;

  always #5 clk = ~clk;

  jtninja_frame_trig #(.START_FRAME(3), .STOP_FRAME(6), .MAX_FRAME(4), .LOADROM(1'b1),
                       .WDOG_CYCLES(50)) dut_a (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld_a), .frame_cnt(frame_cnt_a),
    .frame_edge(fe_a), .dump_en(en_a), .dump_start(st_a), .dump_stop(sp_a),
    .finish(fin_a), .vs_lost(lost_a));

  jtninja_frame_trig #(.START_FRAME(0), .STOP_FRAME(0), .MAX_FRAME(0), .LOADROM(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld_b), .frame_cnt(frame_cnt_b),
    .frame_edge(fe_b), .dump_en(en_b), .dump_start(st_b), .dump_stop(sp_b),
    .finish(fin_b), .vs_lost(lost_b));

  jtninja_frame_trig #(.START_FRAME(0), .STOP_FRAME(0), .MAX_FRAME(0), .LOADROM(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld_a), .frame_cnt(frame_cnt_c),
    .frame_edge(fe_c), .dump_en(en_c), .dump_start(st_c), .dump_stop(sp_c),
    .finish(fin_c), .vs_lost(lost_c));

  jtninja_frame_trig #(.START_FRAME(2), .STOP_FRAME(2), .MAX_FRAME(0), .LOADROM(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld_a), .frame_cnt(frame_cnt_d),
    .frame_edge(fe_d), .dump_en(en_d), .dump_start(st_d), .dump_stop(sp_d),
    .finish(fin_d), .vs_lost(lost_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (fe_a) fe_cnt_a++;
    if (st_a) begin start_cnt_a++; start_at_a = int'(frame_cnt_a); end
    if (sp_a) begin stop_cnt_a++;  stop_at_a  = int'(frame_cnt_a); end
    if (en_a) en_cycles_a++;
    if (st_d) start_cnt_d++;
    if (sp_d) stop_cnt_d++;
    if (en_d) en_cycles_d++;
  end

  initial begin
    rst_n = 1'b0; vs = 1'b1; dwnld_a = 1'b0; dwnld_b = 1'b0;
    step(3);
    check("rst_cnt",  frame_cnt_a, 32'd0);
    check("rst_outs", 32'({fe_a, en_a, st_a, sp_a, fin_a, lost_a}), 32'd0);
    check("rst_en_c", 32'(en_c), 32'd0);

    rst_n = 1'b1;
    check("c_en_cyc1", 32'(en_c), 32'd0);
    step(1);
    check("c_en_cyc2", 32'(en_c), 32'd1);
    check("c_start",   32'(st_c), 32'd1);

    // A frame during WAIT_DL must not be counted.
    vs = 1'b0;
    step(3);
    check("waitdl_fe", 32'(fe_a), 32'd0);
    step(1);
    vs = 1'b1;
    step(4);

    dwnld_a = 1'b1; dwnld_b = 1'b1;
    step(100);
    check("waitdl_lost", 32'(lost_a), 32'd0);
    dwnld_a = 1'b0; dwnld_b = 1'b0;
    step(3);
    check("armed_cnt",  frame_cnt_a, 32'd0);
    check("armed_en_b", 32'(en_b), 32'd0);
    step(1);
    check("b_en_rise",  32'(en_b), 32'd1);
    check("b_start",    32'(st_b), 32'd1);
    check("a_en_armed", 32'(en_a), 32'd0);
    step(48);
    check("wd_49", 32'(lost_a), 32'd0);
    step(1);
    check("wd_50", 32'(lost_a), 32'd1);

    for (int k = 1; k <= 10; k++) begin
      vs = 1'b0;
      if (k == 8) dwnld_b = 1'b1;
      step(2);
      if (k == 1) check("wd_hold", 32'(lost_a), 32'd1);
      step(1);
      check($sformatf("a_fe_%0d", k),    32'(fe_a), 32'd1);
      check($sformatf("a_cnt_%0d", k),   frame_cnt_a, 32'(k));
      check($sformatf("a_lost_%0d", k),  32'(lost_a), 32'd0);
      check($sformatf("a_fin_%0d", k),   32'(fin_a), 32'(k >= 4));
      check($sformatf("a_start_%0d", k), 32'(st_a), 32'(k == 3));
      check($sformatf("a_stop_%0d", k),  32'(sp_a), 32'(k == 6));
      check($sformatf("a_en_%0d", k),    32'(en_a), 32'(k >= 3 && k < 6));
      check($sformatf("b_cnt_%0d", k),   frame_cnt_b, (k <= 7) ? 32'(k) : 32'd7);
      check($sformatf("b_fe_%0d", k),    32'(fe_b), 32'(k <= 7));
      check($sformatf("b_en_%0d", k),    32'(en_b), 32'(k <= 7));
      check($sformatf("b_stop_%0d", k),  32'(sp_b), 32'(k == 8));
      step(1);
      vs = 1'b1;
      step(16);
      if (k == 5) check("a_fe_count5", 32'(fe_cnt_a), 32'd5);
    end

    check("a_fe_total",  32'(fe_cnt_a), 32'd10);
    check("a_starts",    32'(start_cnt_a), 32'd1);
    check("a_stops",     32'(stop_cnt_a), 32'd1);
    check("a_start_at",  32'(start_at_a), 32'd3);
    check("a_stop_at",   32'(stop_at_a), 32'd6);
    check("a_en_cycles", 32'(en_cycles_a), 32'd60);
    check("a_done_en",   32'(en_a), 32'd0);
    check("d_starts",    32'(start_cnt_d), 32'd0);
    check("d_stops",     32'(stop_cnt_d), 32'd0);
    check("d_en_cycles", 32'(en_cycles_d), 32'd0);
    check("d_cnt",       frame_cnt_d, 32'd10);

    dwnld_b = 1'b0;
    step(3);
    check("b_rearm_cnt", frame_cnt_b, 32'd0);
    check("b_rearm_en0", 32'(en_b), 32'd0);
    step(1);
    check("b_rearm_en1", 32'(en_b), 32'd1);
    check("b_rearm_st",  32'(st_b), 32'd1);

    // Asynchronous reset mid-capture: dump_en drops with no stop pulse.
    step(1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_en",   32'(en_b), 32'd0);
    check("rst_mid_stop", 32'(sp_b), 32'd0);
    check("rst_mid_fin",  32'(fin_a), 32'd0);
    check("rst_mid_cnt",  frame_cnt_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
